// File: rtl/tictactoe_move_gen_if.sv
// Purpose : move-request / move-strobe bundle between the game and its automatic opponent.
// Latency : n/a (wires only).
// Backpressure: none; turn requests are dropped while the opponent is busy.
// Ports   : turn_req, board[17:0], game_over  (game -> opponent)
//           move_valid, player, position[3:0], busy, no_move  (opponent -> game)
interface tictactoe_move_gen_if;
   logic        turn_req;
   logic [17:0] board;
   logic        game_over;
   logic        move_valid;
   logic        player;
   logic [3:0]  position;
   logic        busy;
   logic        no_move;

   // master: the move generator
   modport master (
      input  turn_req, board, game_over,
      output move_valid, player, position, busy, no_move
   );

   // slave: the game consuming the moves
   modport slave (
      output turn_req, board, game_over,
      input  move_valid, player, position, busy, no_move
   );
endinterface

// File: rtl/tictactoe_move_gen.sv
// Purpose : automatic tic-tac-toe opponent; snapshots the board, scans win/block/preference, emits one move.
// Latency : move_valid at T2+k (win), T10+k (block), T18+j (preference); no_move at T26 (EN_BLOCK=1).
// Backpressure: none; turn_req while busy is ignored, game_over aborts a search in progress.
// Ports   : clk, reset (async, active-high), mv (master modport: turn_req/board/game_over in,
//           move_valid/player/position/busy/no_move out, all outputs registered).
module tictactoe_move_gen #(
   parameter bit MY_PLAYER = 1'b1,
   parameter bit EN_BLOCK  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   tictactoe_move_gen_if.master   mv
);

   typedef enum logic [2:0] {
      IDLE, SCAN_WIN, SCAN_BLK, SCAN_PREF, ISSUE, NOMOVE
   } state_t;

   localparam logic [1:0] EMPTY    = 2'b00;
   localparam logic [1:0] OWN_CODE = MY_PLAYER ? 2'b10 : 2'b01;
   localparam logic [1:0] OPP_CODE = MY_PLAYER ? 2'b01 : 2'b10;

   state_t      state;
   logic [17:0] snap;
   logic [3:0]  idx;      // line index k (0..7) or preference index j (0..8)

   // Cell n of line k, n = 0..2.
   function automatic logic [3:0] line_cell(input logic [2:0] k, input logic [1:0] n);
      logic [11:0] cells;
      case (k)
         3'd0:    cells = {4'd0, 4'd1, 4'd2};
         3'd1:    cells = {4'd3, 4'd4, 4'd5};
         3'd2:    cells = {4'd6, 4'd7, 4'd8};
         3'd3:    cells = {4'd0, 4'd3, 4'd6};
         3'd4:    cells = {4'd1, 4'd4, 4'd7};
         3'd5:    cells = {4'd2, 4'd5, 4'd8};
         3'd6:    cells = {4'd0, 4'd4, 4'd8};
         default: cells = {4'd2, 4'd4, 4'd6};
      endcase
      case (n)
         2'd0:    line_cell = cells[11:8];
         2'd1:    line_cell = cells[7:4];
         default: line_cell = cells[3:0];
      endcase
   endfunction

   function automatic logic [3:0] pref_cell(input logic [3:0] j);
      case (j)
         4'd0:    pref_cell = 4'd4;
         4'd1:    pref_cell = 4'd0;
         4'd2:    pref_cell = 4'd2;
         4'd3:    pref_cell = 4'd6;
         4'd4:    pref_cell = 4'd8;
         4'd5:    pref_cell = 4'd1;
         4'd6:    pref_cell = 4'd3;
         4'd7:    pref_cell = 4'd5;
         default: pref_cell = 4'd7;
      endcase
   endfunction

   function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] c);
      cell_code = b[{c, 1'b0} +: 2];
   endfunction

   logic [3:0] c0, c1, c2, line_pick, pref_pos;
   logic [1:0] v0, v1, v2, scan_code;
   logic       line_hit, pref_hit;

   always_comb begin
      c0        = line_cell(idx[2:0], 2'd0);
      c1        = line_cell(idx[2:0], 2'd1);
      c2        = line_cell(idx[2:0], 2'd2);
      v0        = cell_code(snap, c0);
      v1        = cell_code(snap, c1);
      v2        = cell_code(snap, c2);
      // Win phase looks for our own pairs, block phase for the opponent's.
      scan_code = (state == SCAN_WIN) ? OWN_CODE : OPP_CODE;
      line_hit  = 1'b0;
      line_pick = 4'd0;
      if (v0 == scan_code && v1 == scan_code && v2 == EMPTY) begin
         line_hit  = 1'b1;
         line_pick = c2;
      end else if (v0 == scan_code && v2 == scan_code && v1 == EMPTY) begin
         line_hit  = 1'b1;
         line_pick = c1;
      end else if (v1 == scan_code && v2 == scan_code && v0 == EMPTY) begin
         line_hit  = 1'b1;
         line_pick = c0;
      end
      pref_pos  = pref_cell(idx);
      pref_hit  = (cell_code(snap, pref_pos) == EMPTY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         snap          <= '0;
         idx           <= '0;
         mv.move_valid <= 1'b0;
         mv.player     <= 1'b0;
         mv.position   <= 4'd0;
         mv.busy       <= 1'b0;
         mv.no_move    <= 1'b0;
      end else begin
         // Strobes are single-cycle; any state that wants them sets them again.
         mv.move_valid <= 1'b0;
         mv.player     <= 1'b0;
         mv.position   <= 4'd0;
         mv.no_move    <= 1'b0;
         case (state)
            IDLE: begin
               if (mv.turn_req && !mv.game_over) begin
                  snap    <= mv.board;
                  idx     <= 4'd0;
                  state   <= SCAN_WIN;
                  mv.busy <= 1'b1;
               end
            end
            SCAN_WIN, SCAN_BLK: begin
               if (mv.game_over) begin
                  state   <= IDLE;
                  mv.busy <= 1'b0;
               end else if (line_hit) begin
                  state         <= ISSUE;
                  mv.move_valid <= 1'b1;
                  mv.player     <= MY_PLAYER;
                  mv.position   <= line_pick;
               end else if (idx == 4'd7) begin
                  idx   <= 4'd0;
                  state <= (state == SCAN_WIN && EN_BLOCK) ? SCAN_BLK : SCAN_PREF;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            SCAN_PREF: begin
               if (mv.game_over) begin
                  state   <= IDLE;
                  mv.busy <= 1'b0;
               end else if (pref_hit) begin
                  state         <= ISSUE;
                  mv.move_valid <= 1'b1;
                  mv.player     <= MY_PLAYER;
                  mv.position   <= pref_pos;
               end else if (idx == 4'd8) begin
                  state      <= NOMOVE;
                  mv.no_move <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin   // ISSUE, NOMOVE: strobe already on the outputs this cycle
               state   <= IDLE;
               mv.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
